// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract unit: carry chain split into STAGES registered segments, valid/ready both sides.
// Define PIPE_ADD_SAT_EN to add the Sat input (signed saturation on overflow).
module pipelined_adder_nbit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
`ifdef PIPE_ADD_SAT_EN
  input  logic             Sat,
`endif
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy
);

  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] v_q, v_d, c_q, c_d;
  logic [STAGES-1:0] ld_s, in_v_s, in_c_s, nxt_c_s;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  bx_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  in_a_s [STAGES];
  logic [WIDTH-1:0]  in_bx_s [STAGES];
  logic [WIDTH-1:0]  in_sum_s [STAGES];
  logic [WIDTH-1:0]  nxt_sum_s [STAGES];
  logic [WIDTH-1:0]  fin_sum_s;
  logic [SEG:0]      seg_s;
  logic              rdy_s, in_ready_s, ovf_new_s, ovf_q, ovf_d, msb_s;
`ifdef PIPE_ADD_SAT_EN
  logic [STAGES-1:0] sat_q, sat_d, in_sat_s;
`endif

  // Ready chain, stage inputs, per-segment carry arithmetic and next-state selection.
  always_comb begin
    rdy_s = Out_Ready;
    ld_s  = '0;
    // A stage may load when it is empty or the stage downstream will move.
    for (int j = STAGES - 1; j >= 0; j--) begin
      rdy_s   = ~v_q[j] | rdy_s;
      ld_s[j] = rdy_s;
    end
    in_ready_s = ld_s[0] & ~Rst;

    in_v_s      = '0;
    in_c_s      = '0;
    in_v_s[0]   = In_Valid & in_ready_s;
    in_c_s[0]   = Sub ? 1'b1 : Cin;
    in_a_s[0]   = A;
    in_bx_s[0]  = Sub ? ~B : B;
    in_sum_s[0] = '0;
`ifdef PIPE_ADD_SAT_EN
    in_sat_s    = '0;
    in_sat_s[0] = Sat;
`endif
    for (int j = 1; j < STAGES; j++) begin
      in_v_s[j]   = v_q[j-1];
      in_c_s[j]   = c_q[j-1];
      in_a_s[j]   = a_q[j-1];
      in_bx_s[j]  = bx_q[j-1];
      in_sum_s[j] = sum_q[j-1];
`ifdef PIPE_ADD_SAT_EN
      in_sat_s[j] = sat_q[j-1];
`endif
    end

    seg_s   = '0;
    nxt_c_s = '0;
    for (int j = 0; j < STAGES; j++) begin
      seg_s = {1'b0, in_a_s[j][j*SEG +: SEG]} + {1'b0, in_bx_s[j][j*SEG +: SEG]}
            + {{SEG{1'b0}}, in_c_s[j]};
      nxt_c_s[j]                   = seg_s[SEG];
      nxt_sum_s[j]                 = in_sum_s[j];
      nxt_sum_s[j][j*SEG +: SEG]   = seg_s[SEG-1:0];
    end

    // Overflow: operands agree in sign but the result does not.
    msb_s     = in_a_s[STAGES-1][WIDTH-1];
    ovf_new_s = (msb_s ~^ in_bx_s[STAGES-1][WIDTH-1]) & (nxt_sum_s[STAGES-1][WIDTH-1] ^ msb_s);
`ifdef PIPE_ADD_SAT_EN
    if (in_sat_s[STAGES-1] & ovf_new_s) begin
      fin_sum_s = {msb_s, {(WIDTH-1){~msb_s}}};
    end else begin
      fin_sum_s = nxt_sum_s[STAGES-1];
    end
`else
    fin_sum_s = nxt_sum_s[STAGES-1];
`endif

    v_d = v_q;
    c_d = c_q;
`ifdef PIPE_ADD_SAT_EN
    sat_d = sat_q;
`endif
    for (int j = 0; j < STAGES; j++) begin
      if (ld_s[j]) begin
        v_d[j]   = in_v_s[j];
        c_d[j]   = nxt_c_s[j];
        a_d[j]   = in_a_s[j];
        bx_d[j]  = in_bx_s[j];
        sum_d[j] = nxt_sum_s[j];
`ifdef PIPE_ADD_SAT_EN
        sat_d[j] = in_sat_s[j];
`endif
      end else begin
        a_d[j]   = a_q[j];
        bx_d[j]  = bx_q[j];
        sum_d[j] = sum_q[j];
      end
    end
    if (ld_s[STAGES-1]) begin
      sum_d[STAGES-1] = fin_sum_s;
      ovf_d           = ovf_new_s;
    end else begin
      ovf_d           = ovf_q;
    end
  end

  // Valid bits and output-visible state, cleared by reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int j = 0; j < STAGES; j++) begin
        sum_q[j] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      sum_q <= sum_d;
    end
  end

  // Pending operand bits travel without reset; valid bits qualify them.
  always_ff @(posedge Clk) begin
    a_q   <= a_d;
    bx_q  <= bx_d;
`ifdef PIPE_ADD_SAT_EN
    sat_q <= sat_d;
`endif
  end

  assign In_Ready  = in_ready_s;
  assign S         = sum_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;
  assign Out_Valid = v_q[STAGES-1];
  assign Busy      = |v_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: directed vectors plus random traffic against an arithmetic reference queue.
// Saturation vectors are included when PIPE_ADD_SAT_EN is defined.
module tb_pipelined_adder_nbit;
  localparam int W  = 32;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sub = 1'b0, sat = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, cout, ovf, out_valid, busy;
  logic [W-1:0] s;

  always #5 clk = ~clk;

  pipelined_adder_nbit #(.WIDTH(W), .STAGES(ST)) dut (
    .Clk(clk), .Rst(rst), .A(a), .B(b), .Cin(cin), .Sub(sub),
`ifdef PIPE_ADD_SAT_EN
    .Sat(sat),
`endif
    .In_Valid(in_valid), .In_Ready(in_ready), .S(s), .Cout(cout), .Ovf(ovf),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Busy(busy)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t         q[$];
  logic [W-1:0] obs_q[$];
  int           checks = 0, errors = 0;
  logic         last_ov, last_acc, last_ir, last_c, last_o;
  logic [W-1:0] last_s;
  logic         stall_pend = 1'b0;
  res_t         stall_v;

  // Reference: wide unsigned sum for S/Cout, true signed result for overflow.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub, input logic msat);
    res_t       r;
    logic [W:0] full;
    longint     sa, sb, sr, smax, smin;
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -smax - 1;
    if (msub) begin
      r.s = ma - mb;
      r.c = (ma >= mb);
      sr  = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      r.s  = full[W-1:0];
      r.c  = full[W];
      sr   = sa + sb + longint'(mcin);
    end
    r.o = (sr > smax) || (sr < smin);
    if (msat && r.o) r.s = (sr > 0) ? smax[W-1:0] : smin[W-1:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at mid-cycle, update the reference queue, advance.
  task automatic tick(input logic iv, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xcin, input logic xsub, input logic xsat,
                      input logic xordy, input logic xrst);
    res_t e;
    rst = xrst; in_valid = iv; a = xa; b = xb; cin = xcin; sub = xsub; sat = xsat;
    out_ready = xordy;
    #1;
    last_ov  = out_valid;
    last_ir  = in_ready;
    last_acc = 1'b0;
    if (xrst) begin
      chk("in_ready_during_reset", in_ready, 1'b0);
    end else begin
      if (stall_pend) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_S", s, stall_v.s);
        chk("stall_Cout", cout, stall_v.c);
        chk("stall_Ovf", ovf, stall_v.o);
      end
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, !(q.size() == ST && !xordy));
      if (q.size() == 0) begin
        chk("out_valid_when_empty", out_valid, 1'b0);
      end else if (out_valid && xordy) begin
        e = q.pop_front();
        chk("S", s, e.s);
        chk("Cout", cout, e.c);
        chk("Ovf", ovf, e.o);
        last_s = s; last_c = cout; last_o = ovf;
        obs_q.push_back(s);
      end
      stall_pend = out_valid && !xordy;
      stall_v    = '{s: s, c: cout, o: ovf};
      if (iv && in_ready) begin
        q.push_back(model(xa, xb, xcin, xsub, xsat));
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    if (xrst) begin
      q.delete();
      stall_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Single transaction into an empty pipe; also measures accept-to-valid latency.
  task automatic single(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xcin, input logic xsub, input logic xsat);
    int n;
    tick(1'b1, xa, xb, xcin, xsub, xsat, 1'b1, 1'b0);
    chk({tag, "_accept"}, last_acc, 1'b1);
    n = 1;
    idle();
    while (!last_ov && n < 20) begin
      n++;
      idle();
    end
    chk({tag, "_latency"}, n, ST);
  endtask

  initial begin
    int           idx, ir_low;
    logic         iv, ordy, xsat;
    logic [W-1:0] xa, xb;
    logic [W-1:0] corner [4];
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF; corner[3] = 32'h8000_0000;

    // Reset state
    tick(1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_S", s, 32'h0);
    chk("rst_Cout", cout, 1'b0);
    chk("rst_Ovf", ovf, 1'b0);
    chk("rst_Out_Valid", out_valid, 1'b0);
    chk("rst_Busy", busy, 1'b0);
    idle();
    chk("in_ready_after_reset", last_ir, 1'b1);

    // Directed arithmetic vectors
    single("tp1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    chk("tp1_S", last_s, 32'h0); chk("tp1_Cout", last_c, 1'b1); chk("tp1_Ovf", last_o, 1'b0);
    single("tp2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    chk("tp2_S", last_s, 32'h8000_0000); chk("tp2_Cout", last_c, 1'b0); chk("tp2_Ovf", last_o, 1'b1);
    single("tp3a", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    chk("tp3a_S", last_s, 32'hFFFF_FFFE); chk("tp3a_Cout", last_c, 1'b0); chk("tp3a_Ovf", last_o, 1'b0);
    single("tp3b", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    chk("tp3b_S", last_s, 32'h0000_0002); chk("tp3b_Cout", last_c, 1'b1);
    single("cin", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    chk("cin_S", last_s, 32'h0001_0000);

    // Backpressure: six back-to-back inputs, consumer stalls three cycles after the first result
    obs_q.delete();
    idx = 1;
    ir_low = 0;
    for (int cyc = 0; cyc < 40 && (idx <= 6 || q.size() > 0); cyc++) begin
      ordy = !(cyc >= ST && cyc < ST + 3);
      tick(idx <= 6, W'(idx), W'(idx), 1'b0, 1'b0, 1'b0, ordy, 1'b0);
      if (last_acc) idx++;
      if (!last_ir) ir_low++;
    end
    chk("bp_in_ready_dropped", ir_low > 0, 1'b1);
    chk("bp_count", obs_q.size(), 6);
    for (int k = 0; k < 6 && k < obs_q.size(); k++) chk("bp_order", obs_q[k], W'(2 * (k + 1)));

    // Reset with two transactions in flight
    tick(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("midrst_Out_Valid", last_ov, 1'b0);
    chk("midrst_In_Ready", last_ir, 1'b1);
    for (int k = 0; k < 8; k++) idle();

`ifdef PIPE_ADD_SAT_EN
    single("sat_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    chk("sat_pos_S", last_s, 32'h7FFF_FFFF); chk("sat_pos_Ovf", last_o, 1'b1);
    single("sat_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    chk("sat_neg_S", last_s, 32'h8000_0000); chk("sat_neg_Ovf", last_o, 1'b1);
    single("sat_off", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    chk("sat_off_S", last_s, 32'h8000_0000);
`endif

    // Random traffic with random backpressure and occasional corner operands
    for (int k = 0; k < 400; k++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      xa   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      xb   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
`ifdef PIPE_ADD_SAT_EN
      xsat = 1'($urandom_range(0, 1));
`else
      xsat = 1'b0;
`endif
      tick(iv, xa, xb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), xsat, ordy, 1'b0);
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) idle();
    chk("drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_adder_nbit.md
Name: pipelined_adder_nbit

Overview:
Parametrised, pipelined add/subtract unit, the successor to the fixed 32-bit ripple adder. The carry chain is split into STAGES equal segments, with a register boundary after each segment, which lets WIDTH scale without lengthening the critical path. It carries a valid/ready handshake on both sides with full backpressure, plus a subtract mode and a signed-overflow flag. It sits between an operand producer (ALU issue) and a result consumer (writeback).

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages / carry segments (1..WIDTH); the segment width is SEG = WIDTH/STAGES.

Ports:
Clk  input  1  single clock, all state on rising edge
Rst  input  1  synchronous reset, active-high
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Cin  input  1  carry-in (add mode only)
Sub  input  1  0 = A+B+Cin; 1 = A-B
In_Valid  input  1  operands valid
In_Ready  output  1  unit can accept operands this cycle
S  output  WIDTH  result
Cout  output  1  carry-out (add) / no-borrow (sub; 1 when A>=B unsigned)
Ovf  output  1  signed overflow
Out_Valid  output  1  S/Cout/Ovf valid
Out_Ready  input  1  consumer accepts result
Busy  output  1  any stage holds a valid transaction

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Operand preparation at input: Bx = Sub ? ~B : B; c0 = Sub ? 1 : Cin. In sub mode Cin is ignored.
- Stage k (1..STAGES) computes sum bits [k*SEG-1:(k-1)*SEG] from the registered carry of stage k-1 (stage 1 uses c0).
- Each stage registers: V_k, its carry-out, the sum bits computed so far, and the not-yet-consumed A/Bx bits.
- Stage STAGES registers are the outputs: S, Cout = final carry, Ovf = carry into MSB XOR final carry.
- Ready chain is combinational: R_(STAGES+1) = Out_Ready; R_k = ~V_k | R_(k+1).
- Stage k loads when R_k = 1; V_1 loads In_Valid & In_Ready; V_k loads V_(k-1) for k>1.
- In_Ready = R_1 & ~Rst. Out_Valid = V_STAGES. Busy = OR of all V_k.
- Transfer rules: input transfer when In_Valid & In_Ready at an edge; output transfer when Out_Valid & Out_Ready.
- Latency: an input transfer at edge n gives Out_Valid = 1 after edge n+STAGES-1 (STAGES cycles including the accept edge), provided there are no stalls.
- Throughput is 1 per cycle while Out_Ready = 1.
- Out_Valid stays high and S/Cout/Ovf stay stable until an output transfer occurs.
- Results leave in acceptance order, with no loss or duplication.
- Full: with all V_k = 1 and Out_Ready = 0, In_Ready = 0. Simultaneous output and input transfer in the full state is allowed; occupancy is unchanged.
- Empty: Out_Valid = 0, Busy = 0, In_Ready = 1.
- Wrap-around: S is modulo 2^WIDTH, and Cout carries the lost bit.
- Reset values: all V_k = 0; S = 0, Cout = 0, Ovf = 0, Out_Valid = 0, Busy = 0. In_Ready = 0 while Rst is high and 1 in the first cycle after.
- Reset mid-operation: all in-flight transactions are discarded, and no stale result appears after reset.
- Internal data registers (not V_k) need no reset.
- STAGES = 1: a single registered full-width adder with the same handshake.

Optional Feature:
PIPE_ADD_SAT_EN
- Defined: an extra input port Sat (1 bit) travels with the operands down the pipe.
- When Sat = 1 and the final Ovf = 1, S clamps to the signed maximum (0111..1) if the true result is positive, or to the signed minimum (1000..0) if it is negative. Ovf still reports 1 and Cout is unchanged.
- Sat = 0 gives wrapped results.
- Not defined: no Sat port; results are always wrapped; no extra registers.

Test Plan:
WIDTH=32, STAGES=4 unless noted.
1. Add wrap: A=FFFFFFFF, B=00000001, Cin=0, Sub=0 accepted at edge n -> after edge n+3: Out_Valid=1, S=00000000, Cout=1, Ovf=0.
2. Signed overflow: A=7FFFFFFF, B=00000001 -> S=80000000, Cout=0, Ovf=1.
3. Subtract with borrow: A=00000005, B=00000007, Sub=1, Cin=1 (ignored) -> S=FFFFFFFE, Cout=0, Ovf=0. A=7, B=5 -> S=00000002, Cout=1.
4. Backpressure: 6 back-to-back inputs (A=i, B=i, i=1..6); Out_Ready held 0 for 3 cycles after the first Out_Valid -> In_Ready=0 once 4 stages are full; outputs 2,4,6,8,10,12 appear in order with no drop or repeat; S is stable while stalled.
5. Reset mid-flight: 2 transactions in the pipe, Rst=1 for one cycle -> Out_Valid=0, Busy=0, In_Ready=1 on the next cycle, and no old result ever appears.
6. PIPE_ADD_SAT_EN defined: A=7FFFFFFF, B=1, Sat=1 -> S=7FFFFFFF, Ovf=1. A=80000000, B=1, Sub=1, Sat=1 -> S=80000000, Ovf=1. Repeat the first case with Sat=0 -> S=80000000. Repeat case 1 with STAGES=1 -> result after edge n.
